// File: rtl/adder_bist_ctrl.sv
// rtl/adder_bist_ctrl.sv - BIST driver/checker for the registered adder; optional corners via ADDER_BIST_CORNERS_EN
module adder_bist_ctrl #(
    parameter int          WIDTH   = 25,
    parameter int          LATENCY = 2,
    parameter logic [31:0] SEED    = 32'hACE1_2025
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [15:0]      num_vec,
    output logic [WIDTH-1:0] a_out,
    output logic [WIDTH-1:0] b_out,
    input  logic [WIDTH-1:0] sum_in,
    input  logic             ovf_in,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [15:0]      err_count,
    output logic [15:0]      first_err_idx
);

    localparam logic [31:0] TAPS = 32'h8020_0003;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return (s >> 1) ^ (s[0] ? TAPS : 32'h0);
    endfunction

`ifdef ADDER_BIST_CORNERS_EN
    function automatic logic [WIDTH-1:0] alt_pattern();
        logic [WIDTH-1:0] p;
        for (int i = 0; i < WIDTH; i++) p[i] = (((WIDTH - 1 - i) % 2) == 0);
        return p;
    endfunction
`endif

    state_t state, state_nx;

    logic [15:0]      num_lat;
    logic [15:0]      vec_idx;
    logic [15:0]      last_idx;
    logic [31:0]      lfsr;
    logic             clear, launch;
    logic [15:0]      launch_idx;
    logic [31:0]      lfsr_src, step1, step2, lfsr_nx;
    logic [WIDTH-1:0] a_nx, b_nx;
    logic [WIDTH:0]   exp_nx;

    // Scoreboard: entry k holds the vector launched k edges ago
    logic [LATENCY:0]             sb_vld;
    logic [LATENCY:0]             sb_ovf;
    logic [LATENCY:0][15:0]       sb_idx;
    logic [LATENCY:0][WIDTH-1:0]  sb_sum;

    logic cmp_vld, mismatch, last_cmp;

    assign last_idx = num_lat - 16'd1;
    assign cmp_vld  = sb_vld[LATENCY];
    assign mismatch = cmp_vld && ({ovf_in, sum_in} != {sb_ovf[LATENCY], sb_sum[LATENCY]});
    assign last_cmp = cmp_vld && (sb_idx[LATENCY] == last_idx);

    always_comb begin
        state_nx = state;
        clear    = 1'b0;
        launch   = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    clear = 1'b1;
                    if (num_vec != 16'd0) begin
                        launch   = 1'b1;
                        state_nx = (num_vec == 16'd1) ? DRAIN : RUN;
                    end else begin
                        state_nx = DONE;
                    end
                end
            end
            RUN: begin
                launch = 1'b1;
                if (vec_idx == last_idx) state_nx = DRAIN;
            end
            DRAIN: begin
                if (last_cmp) state_nx = DONE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        launch_idx = clear ? 16'd0 : vec_idx;
        lfsr_src   = clear ? SEED : lfsr;
        step1      = lfsr_step(lfsr_src);
        step2      = lfsr_step(step1);
        a_nx       = step1[WIDTH-1:0];
        b_nx       = step2[WIDTH-1:0];
        lfsr_nx    = step2;
`ifdef ADDER_BIST_CORNERS_EN
        // Corner slots leave the LFSR untouched so index 4 sees the seed sequence
        if (launch_idx < 16'd4) begin
            lfsr_nx = lfsr_src;
            case (launch_idx[1:0])
                2'd0: begin a_nx = '0; b_nx = '0; end
                2'd1: begin a_nx = '1; b_nx = {{(WIDTH-1){1'b0}}, 1'b1}; end
                2'd2: begin a_nx = '1; b_nx = '1; end
                default: begin a_nx = alt_pattern(); b_nx = ~alt_pattern(); end
            endcase
        end
`endif
        exp_nx = {1'b0, a_nx} + {1'b0, b_nx};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            num_lat       <= '0;
            vec_idx       <= '0;
            lfsr          <= SEED;
            a_out         <= '0;
            b_out         <= '0;
            err_count     <= '0;
            first_err_idx <= 16'hFFFF;
            sb_vld        <= '0;
            sb_ovf        <= '0;
            sb_idx        <= '0;
            sb_sum        <= '0;
        end else begin
            state <= state_nx;

            if (clear) begin
                num_lat       <= num_vec;
                err_count     <= '0;
                first_err_idx <= 16'hFFFF;
            end else if (mismatch) begin
                if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
                if (err_count == 16'd0) first_err_idx <= sb_idx[LATENCY];
            end

            if (launch) begin
                a_out   <= a_nx;
                b_out   <= b_nx;
                lfsr    <= lfsr_nx;
                vec_idx <= launch_idx + 16'd1;
            end else if (clear) begin
                lfsr    <= SEED;
                vec_idx <= '0;
            end

            sb_vld <= {sb_vld[LATENCY-1:0], launch};
            sb_ovf <= {sb_ovf[LATENCY-1:0], exp_nx[WIDTH]};
            sb_idx <= {sb_idx[LATENCY-1:0], launch_idx};
            sb_sum <= {sb_sum[LATENCY-1:0], exp_nx[WIDTH-1:0]};
        end
    end

    assign busy = (state == RUN) || (state == DRAIN);
    assign done = (state == DONE);
    assign pass = done && (err_count == 16'd0);

endmodule

// File: tb/tb_adder_bist_ctrl.sv
// tb/tb_adder_bist_ctrl.sv - directed bench for adder_bist_ctrl with a two-stage adder model
module tb_adder_bist_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [15:0] num_vec = 16'd0;
    logic [24:0] a_out, b_out, sum_in;
    logic        ovf_in;
    logic        busy, done, pass;
    logic [15:0] err_count, first_err_idx;

    int total = 0;
    int bad   = 0;

    logic        fault = 1'b0;
    logic [24:0] ar = '0, br = '0, sum_r = '0;
    logic        ovf_r = 1'b0;

    adder_bist_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .num_vec(num_vec),
        .a_out(a_out), .b_out(b_out), .sum_in(sum_in), .ovf_in(ovf_in),
        .busy(busy), .done(done), .pass(pass),
        .err_count(err_count), .first_err_idx(first_err_idx)
    );

    always #5 clk = ~clk;

    // Registered adder: input stage then output stage
    always_ff @(posedge clk) begin
        ar <= a_out;
        br <= b_out;
        {ovf_r, sum_r} <= {1'b0, ar} + {1'b0, br};
    end
    assign sum_in = fault ? {sum_r[24:1], 1'b0} : sum_r;
    assign ovf_in = ovf_r;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] step(input logic [31:0] s);
        return s[0] ? ((s >> 1) ^ 32'h8020_0003) : (s >> 1);
    endfunction

    // Number of odd expected sums and the first such index for an n-vector run
    task automatic model(input int n, output int odd, output int first);
        logic [31:0] s;
        logic [24:0] a, b;
        logic [25:0] r;
        s = 32'hACE1_2025;
        odd = 0;
        first = 16'hFFFF;
        for (int i = 0; i < n; i++) begin
`ifdef ADDER_BIST_CORNERS_EN
            if (i < 4) begin
                case (i)
                    0: begin a = 25'h0; b = 25'h0; end
                    1: begin a = 25'h1FFFFFF; b = 25'h1; end
                    2: begin a = 25'h1FFFFFF; b = 25'h1FFFFFF; end
                    default: begin a = 25'h1555555; b = 25'h0AAAAAA; end
                endcase
            end else begin
                s = step(s); a = s[24:0];
                s = step(s); b = s[24:0];
            end
`else
            s = step(s); a = s[24:0];
            s = step(s); b = s[24:0];
`endif
            r = {1'b0, a} + {1'b0, b};
            if (r[0]) begin
                if (odd == 0) first = i;
                odd++;
            end
        end
    endtask

    task automatic run(input int n, input bit poke, output int k, output int bcnt,
                       output logic [24:0] a0, output logic [24:0] b0,
                       output logic [24:0] a3, output logic [24:0] b3);
        @(negedge clk);
        start = 1'b1;
        num_vec = n[15:0];
        @(negedge clk);
        start = 1'b0;
        k = 0;
        bcnt = 0;
        a0 = 'x; b0 = 'x; a3 = 'x; b3 = 'x;
        while (!done && k < 300) begin
            if (busy) bcnt++;
            if (k == 0) begin a0 = a_out; b0 = b_out; end
            if (k == 3) begin a3 = a_out; b3 = b_out; end
            if (poke && k == 2) begin
                start = 1'b1;
                num_vec = 16'd3;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            k++;
        end
        start = 1'b0;
    endtask

    initial begin
        int k, bcnt, odd, first;
        logic [24:0] a0, b0, a3, b3;

        #1 rst = 1'b1;
        @(negedge clk);
        check("rst_a", a_out, 0);
        check("rst_b", b_out, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_pass", pass, 0);
        check("rst_err", err_count, 0);
        check("rst_first", first_err_idx, 16'hFFFF);
        rst = 1'b0;

        // Clean 10-vector run
        run(10, 1'b0, k, bcnt, a0, b0, a3, b3);
        check("run10_done_edge", k, 12);
        check("run10_busy_cycles", bcnt, 12);
        check("run10_done", done, 1);
        check("run10_pass", pass, 1);
        check("run10_err", err_count, 0);
        check("run10_first", first_err_idx, 16'hFFFF);
`ifndef ADDER_BIST_CORNERS_EN
        check("vec0_a", a0, 25'h0509011);
        check("vec0_b", b0, 25'h108480B);
`endif

        // Sum LSB stuck at zero
        fault = 1'b1;
        model(10, odd, first);
        run(10, 1'b0, k, bcnt, a0, b0, a3, b3);
        check("lsb0_done_edge", k, 12);
        check("lsb0_pass", pass, 0);
        check("lsb0_err", err_count, odd);
        check("lsb0_first", first_err_idx, first);
        fault = 1'b0;

        // Zero-length run
        run(0, 1'b0, k, bcnt, a0, b0, a3, b3);
        check("n0_done_edge", k, 0);
        check("n0_busy_cycles", bcnt, 0);
        check("n0_pass", pass, 1);
        check("n0_err", err_count, 0);

        // start/num_vec poked during RUN are ignored
        run(10, 1'b1, k, bcnt, a0, b0, a3, b3);
        check("poke_done_edge", k, 12);
        check("poke_busy_cycles", bcnt, 12);
        check("poke_pass", pass, 1);
        check("poke_err", err_count, 0);

`ifdef ADDER_BIST_CORNERS_EN
        run(4, 1'b0, k, bcnt, a0, b0, a3, b3);
        check("corner_done_edge", k, 6);
        check("corner_pass", pass, 1);
        check("corner_a0", a0, 25'h0);
        check("corner_a3", a3, 25'h1555555);
        check("corner_b3", b3, 25'h0AAAAAA);
        fault = 1'b1;
        run(4, 1'b0, k, bcnt, a0, b0, a3, b3);
        check("corner_lsb0_err", err_count, 1);
        check("corner_lsb0_first", first_err_idx, 3);
        fault = 1'b0;
`endif

        // Reset in the middle of a run
        @(negedge clk);
        start = 1'b1;
        num_vec = 16'd10;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        check("mid_busy_before", busy, 1);
        rst = 1'b1;
        #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_a", a_out, 0);
        check("mid_rst_first", first_err_idx, 16'hFFFF);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("idle_a", a_out, 0);
        check("idle_b", b_out, 0);
        check("idle_busy", busy, 0);
        check("idle_err", err_count, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/adder_bist_ctrl.md
Name: adder_bist_ctrl

Overview:
- Built-in self-test controller: the driving and checking end of the registered 25-bit adder interface.
- Generates operand pairs on A/B and computes the expected sum/overflow internally.
- Samples the adder's registered sum/overflow after the pipeline latency, compares it, and reports pass/fail plus error statistics.
- Sits beside the adder top level on FPGA builds so the adder can be exercised in hardware without external stimulus.

Parameters:
- WIDTH, 25, operand/sum width; legal range 2..32.
- LATENCY, 2, register stages inside the adder top level (input register plus output register).
- SEED, 32'hACE1_2025, LFSR reset/start value; must be nonzero.

Ports:
- clk  in  1  rising-edge clock shared with the adder.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle request to begin a run; honoured only in IDLE or DONE.
- num_vec  in  16  number of operand pairs per run; sampled on the accepted start.
- a_out  out  WIDTH  operand A to the adder (registered).
- b_out  out  WIDTH  operand B to the adder (registered).
- sum_in  in  WIDTH  registered sum returned by the adder.
- ovf_in  in  1  registered overflow returned by the adder (carry out of bit WIDTH-1).
- busy  out  1  high in RUN and DRAIN.
- done  out  1  high in DONE.
- pass  out  1  high in DONE when err_count==0.
- err_count  out  16  mismatching vectors; saturates at 16'hFFFF.
- first_err_idx  out  16  index of the first mismatching vector; 16'hFFFF if none.

Behaviour:
- Reset (async, rst=1):
  - a_out=0, b_out=0, busy=0, done=0, pass=0, err_count=0, first_err_idx=16'hFFFF.
  - LFSR=SEED, FSM=IDLE, all pipeline valid bits cleared.
  - Reset mid-run aborts immediately; no partial status is retained.
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE/DONE + start:
    - Clear counters and set first_err_idx=16'hFFFF.
    - LFSR reloads SEED; latch num_vec.
    - If num_vec==0, go to DONE with pass=1.
    - Otherwise go to RUN; vector 0 is driven on a_out/b_out at this same edge.
  - RUN: one vector is launched per cycle (indices 0..N-1). After launching N-1, go to DRAIN.
  - DRAIN: no new vectors; a_out/b_out hold their last values. When the last compare occurs, go to DONE.
  - DONE: status outputs hold until the next start or reset.
  - start in RUN/DRAIN is ignored.
- Operand generation:
  - 32-bit Galois LFSR, taps 32'h8020_0003, shifting right.
  - The LFSR advances twice per vector: a = first state[WIDTH-1:0], b = second state[WIDTH-1:0].
- Expected value: {exp_ovf, exp_sum} = a + b, computed WIDTH+1 bits wide with unsigned carry-out.
- Scoreboard pipeline:
  - Depth LATENCY+1; entries carry {valid, index, exp_ovf, exp_sum}.
  - A vector launched at edge t is compared against sum_in/ovf_in at edge t+LATENCY+1.
- Mismatch handling:
  - A mismatch is any difference in sum or overflow.
  - On a mismatch, err_count increments (saturating).
  - On the first mismatch of a run, first_err_idx = index.
- Run timing: the start edge is edge s.
  - The last compare is at edge s+N+LATENCY.
  - DONE, done and pass are registered at that same edge, with the last compare already included.
  - busy is high for exactly N+LATENCY cycles.

Optional Feature:
- Macro: ADDER_BIST_CORNERS_EN.
- Defined: vectors 0..3 are fixed corner cases; LFSR vectors follow from index 4 and the LFSR does not advance for the corner slots.
  - Vector 0: a=0, b=0.
  - Vector 1: a=all-ones, b=1.
  - Vector 2: a=all-ones, b=all-ones.
  - Vector 3: a=alternating 1010.. (MSB=1), b=its complement.
  - If num_vec<4, only the first num_vec corner vectors run.
- Undefined: all vectors come from the LFSR.

Test Plan:
1. Reset: rst=1 mid-RUN -> next cycle all outputs at reset values, busy=0, first_err_idx=16'hFFFF; with rst=0 and no start, a_out stays 0.
2. Loopback to a correct WIDTH=25 adder top level, num_vec=10, start at edge s -> busy high 12 cycles, done=1 at s+12, pass=1, err_count=0.
3. Same setup with sum_in[0] forced to 0 -> pass=0; err_count = number of odd expected sums among the 10 vectors; first_err_idx = index of the first odd expected sum.
4. num_vec=0 -> done=1 one edge after start, pass=1, busy never asserted.
5. ADDER_BIST_CORNERS_EN, num_vec=4, correct adder -> expected {ovf,sum} per vector, all matching, pass=1:
   - Vector 0: {0, 0}.
   - Vector 1: {1, 25'h0000000}.
   - Vector 2: {1, 25'h1FFFFFE}.
   - Vector 3: a=25'h1555555, b=25'h0AAAAAA -> {0, 25'h1FFFFFF}.
6. start pulsed again during RUN -> ignored; num_vec changed mid-run -> ignored; done timing unchanged from scenario 2.
